// File: rtl/eth_phy_rx_ipg_ext.sv
// IPG side-channel extractor: reassembles IPG message blocks, packs payload into OUT_BYTES words, and queues them in a show-ahead FIFO.
// Define IPG_EXT_STATS_EN to add the msg_count/drop_count statistics ports.
module eth_phy_rx_ipg_ext #(
    parameter int         DATA_WIDTH = 64,
    parameter int         HDR_WIDTH  = 2,
    parameter logic [7:0] IPG_TYPE   = 8'h99,
    parameter int         OUT_BYTES  = 8,
    parameter int         FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [HDR_WIDTH-1:0]   in_hdr,
    input  logic                   in_valid,
    output logic [OUT_BYTES*8-1:0] m_data,
    output logic [OUT_BYTES-1:0]   m_keep,
    output logic                   m_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   bad_block,
    output logic                   overflow,
    output logic                   busy
`ifdef IPG_EXT_STATS_EN
    ,
    output logic [15:0]            msg_count,
    output logic [15:0]            drop_count
`endif
);

    localparam int CAP  = DATA_WIDTH/8 - 2;
    localparam int OW   = OUT_BYTES*8;
    localparam int CW   = 2*OW;
    localparam int PW   = CAP*8;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DROP} state_e;

    state_e              state_q, state_d;
    logic [OW-1:0]       res_q, res_d;
    logic [4:0]          r_q, r_d;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]     cnt_q;
    logic                bad_q, ovf_q;

    logic [OW-1:0]        mem_data [FIFO_DEPTH];
    logic [OUT_BYTES-1:0] mem_keep [FIFO_DEPTH];
    logic                 mem_last [FIFO_DEPTH];

    logic [3:0]           n;
    logic                 lst;
    logic                 is_ipg, malformed, active, pop, ovf_ev, full;
    logic [PW-1:0]        pay_m;
    logic [CW-1:0]        comb_w;
    logic [5:0]           sum, rem;
    logic [OW-1:0]        rem_word;
    logic [OUT_BYTES-1:0] rem_keep;
    logic [1:0]           wr_cnt, wr_n;
    logic [OW-1:0]        ent0_data;
    logic [OUT_BYTES-1:0] ent0_keep;
    logic                 ent0_last;
    int                   free;

    // Length-field bits [6:4] are reserved and carry no meaning here.
    logic unused_len_bits;
    assign unused_len_bits = ^in_data[14:12];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign n         = in_data[11:8];
    assign lst       = in_data[15];
    assign is_ipg    = in_valid && (in_hdr == HDR_WIDTH'(2'b10)) && (in_data[7:0] == IPG_TYPE);
    assign malformed = is_ipg && (((n == 4'd0) && !lst) || ({1'b0, n} > 5'(CAP)));
    assign active    = is_ipg && !malformed && (state_q != S_DROP);
    assign pop       = m_valid && m_ready;

    always_comb begin
        pay_m = '0;
        for (int k = 0; k < CAP; k++) begin
            if (k < int'(n)) pay_m[8*k +: 8] = in_data[16+8*k +: 8];
        end
    end

    // Residual bytes sit below the new payload; bytes above r_q in res_q are always zero.
    always_comb begin
        comb_w   = CW'(res_q) | (CW'(pay_m) << {r_q, 3'b000});
        sum      = {1'b0, r_q} + {2'b00, n};
        full     = (sum >= 6'(OUT_BYTES));
        rem      = full ? (sum - 6'(OUT_BYTES)) : sum;
        rem_word = full ? comb_w[OW +: OW] : comb_w[0 +: OW];
        rem_keep = '0;
        for (int i = 0; i < OUT_BYTES; i++) rem_keep[i] = (i < int'(rem));
    end

    always_comb begin
        wr_cnt = 2'd0;
        if (active) wr_cnt = {1'b0, full} + {1'b0, lst && (rem != 6'd0)};
        free   = FIFO_DEPTH - int'(cnt_q) + int'(pop);
        ovf_ev = active && (int'(wr_cnt) > free);
        wr_n   = ovf_ev ? 2'd0 : wr_cnt;
        if (full) begin
            ent0_data = comb_w[0 +: OW];
            ent0_keep = '1;
            ent0_last = lst && (rem == 6'd0);
        end else begin
            ent0_data = rem_word;
            ent0_keep = rem_keep;
            ent0_last = 1'b1;
        end
    end

    always_comb begin
        r_d   = r_q;
        res_d = res_q;
        if (is_ipg) begin
            if (active && !ovf_ev && !lst) begin
                r_d   = rem[4:0];
                res_d = rem_word;
            end else begin
                r_d   = '0;
                res_d = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (is_ipg) begin
            case (state_q)
                S_IDLE, S_ACCUM: begin
                    if (malformed)   state_d = S_IDLE;
                    else if (ovf_ev) state_d = lst ? S_IDLE : S_DROP;
                    else             state_d = lst ? S_IDLE : S_ACCUM;
                end
                S_DROP:  if (malformed || lst) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            r_q      <= '0;
            res_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            bad_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            res_q    <= res_d;
            wr_ptr_q <= wr_ptr_q + AW'(wr_n);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            cnt_q    <= cnt_q + CNTW'(wr_n) - CNTW'(pop);
            bad_q    <= malformed;
            ovf_q    <= ovf_ev;
        end
    end

    // A completing block may write the full word and the remainder word together.
    always_ff @(posedge clk) begin
        if (wr_n != 2'd0) begin
            mem_data[wr_ptr_q] <= ent0_data;
            mem_keep[wr_ptr_q] <= ent0_keep;
            mem_last[wr_ptr_q] <= ent0_last;
        end
        if (wr_n == 2'd2) begin
            mem_data[wr_ptr_q + AW'(1)] <= rem_word;
            mem_keep[wr_ptr_q + AW'(1)] <= rem_keep;
            mem_last[wr_ptr_q + AW'(1)] <= 1'b1;
        end
    end

    assign m_valid   = (cnt_q != '0);
    assign m_data    = m_valid ? mem_data[rd_ptr_q] : '0;
    assign m_keep    = m_valid ? mem_keep[rd_ptr_q] : '0;
    assign m_last    = m_valid ? mem_last[rd_ptr_q] : 1'b0;
    assign bad_block = bad_q;
    assign overflow  = ovf_q;

`ifdef IPG_EXT_STATS_EN
    logic [15:0] msg_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (active && !ovf_ev && lst) msg_cnt_q <= sat_inc(msg_cnt_q);
            if ((malformed && (state_q != S_DROP)) || ovf_ev) drop_cnt_q <= sat_inc(drop_cnt_q);
        end
    end

    assign msg_count  = msg_cnt_q;
    assign drop_count = drop_cnt_q;
`endif

endmodule
